fetch_pc_unit: RTL and testbench
================================

# fetch_pc_unit

Program-counter and instruction-fetch stage that consumes the byte-aligned branch offset produced by the one-bit left-shift stage. Holds the PC and computes sequential and branch-target addresses. Runs a single-outstanding request/grant/response handshake to instruction memory and presents fetched instructions to decode through a valid/ready interface.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset; first fetch address
- PC_INC, 4, sequential increment in bytes
- clk_i  in  1  single clock, all state on rising edge
- rst_n_i  in  1  asynchronous, active-low reset
- branch_i  in  1  redirect request, one-cycle pulse
- base_i  in  32  PC of the redirecting instruction
- offset_i  in  32  shifted byte offset, bit0 = 0
- imem_req_o  out  1  fetch request
- imem_addr_o  out  32  fetch address, equals current PC
- imem_gnt_i  in  1  memory accepted request this cycle
- imem_rvalid_i  in  1  response data valid
- imem_rdata_i  in  32  response instruction word
- instr_valid_o  out  1  instruction available to decode
- instr_ready_i  in  1  decode accepts instruction
- instr_o  out  32  held instruction word
- instr_pc_o  out  32  PC of held instruction
- misalign_o  out  1  target fault (only with PC_MISALIGN_TRAP_EN, else tied 0)

## Operation
- target = base_i + offset_i, modulo 2^32; carry discarded.
- Sequential next PC = pc + PC_INC, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- States: IDLE, REQ, WAIT, HOLD, FAULT. Kill flag `kill` is 1 bit.
- IDLE: reset state. Goes to REQ unconditionally on the first edge after reset release.
- REQ: imem_req_o=1, imem_addr_o=pc.
  - On imem_gnt_i=1, go to WAIT.
  - branch_i in REQ: pc<=target and stay in REQ. The address changes; this is legal because memory samples only on gnt.
  - If branch_i and gnt occur together, the granted address (old pc) is killed: kill<=1, pc<=target, go to WAIT.
- WAIT: imem_req_o=0. Only one request is ever outstanding.
  - On imem_rvalid_i with kill=0: capture instr_o<=rdata and instr_pc_o<=pc, go to HOLD.
  - On imem_rvalid_i with kill=1: discard the data, clear kill, go to REQ.
  - branch_i in WAIT: pc<=target, kill<=1.
  - If branch_i and rvalid occur together: discard the data, pc<=target, go to REQ.
- HOLD: instr_valid_o=1; instr_o and instr_pc_o are stable until the transfer.
  - On instr_valid_o & instr_ready_i: pc<=pc+PC_INC, go to REQ.
  - branch_i in HOLD: pc<=target, instr_valid_o drops next cycle, go to REQ.
  - If branch_i and ready occur together, the transfer counts as done and pc takes target; the branch wins over the increment.
- branch_i has priority over every other event in every state.

## Timing
- Reset values: pc=RESET_PC, state=IDLE, kill=0, imem_req_o=0, imem_addr_o=RESET_PC, instr_valid_o=0, instr_o=0, instr_pc_o=0, misalign_o=0.
- Reset asserted mid-transaction aborts immediately. Any late imem_rvalid_i after reset is ignored until a request has been granted.
- Minimum latency: req in cycle N with gnt in N, rvalid in N+1, instr_valid_o high in N+2.
- Throughput is at most one instruction per 3 cycles; no fetch overlap.
- imem_addr_o and imem_req_o are registered outputs with no combinational path from inputs.
- target is registered into pc, so the redirect address appears on imem_addr_o the cycle after branch_i.

## Configuration
- PC_MISALIGN_TRAP_EN defined:
  - A target with target[1:0]!=0 loads pc, issues no fetch, and enters FAULT. misalign_o=1, instr_valid_o=0.
  - FAULT is left only by branch_i; the next target is checked the same way.
  - Any outstanding response is discarded via kill.
- PC_MISALIGN_TRAP_EN undefined: target[1:0] is forced to 2'b00, FAULT is unreachable, and misalign_o is constant 0.

## Test plan
- Reset release, gnt same cycle, rvalid next cycle with rdata=32'h0000_0013: instr_valid_o in cycle 2, instr_pc_o=0, instr_o=32'h0000_0013. Next request address is 4.
- Ready held low for 5 cycles in HOLD: instr_o and instr_pc_o are stable and imem_req_o stays 0. Ready=1 causes the next imem_addr_o to be the old PC+4.
- branch_i in WAIT with base=32'h100, offset=32'h40: the following rvalid is dropped (instr_valid_o stays 0), then imem_addr_o=32'h140.
- branch_i in the same cycle as gnt at addr 8, base=0, offset=32'h20: the response for 8 is discarded and the next request is at 32'h20.
- Wrap: pc=32'hFFFF_FFFC accepted by decode gives the next fetch at 32'h0. base=32'hFFFF_FFF0 with offset=32'h20 gives target 32'h10.
- Target 32'h102:
  - With PC_MISALIGN_TRAP_EN: misalign_o=1 and no imem_req_o until branch_i to 32'h200.
  - Without PC_MISALIGN_TRAP_EN: fetch at 32'h100.

Source files
------------

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: program counter and single-outstanding instruction fetch.
// Holds the PC, forms sequential and branch-target addresses, runs the
// req/gnt/rvalid handshake to instruction memory and hands fetched words
// to decode over valid/ready.
// Optional feature macro: PC_MISALIGN_TRAP_EN (misaligned branch targets
// enter a FAULT state instead of being forced to word alignment).
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_INC   = 32'd4
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        branch_i,
    input  logic [31:0] base_i,
    input  logic [31:0] offset_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        misalign_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_FAULT = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        kill_q, kill_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;

    logic [31:0] target_sum;
    logic [31:0] target;
    logic        target_bad;

    // Branch target: base plus pre-shifted byte offset, carry discarded.
    always_comb begin
        target_sum = base_i + offset_i;
`ifdef PC_MISALIGN_TRAP_EN
        target     = target_sum;
        target_bad = |target_sum[1:0];
`else
        target     = {target_sum[31:2], 2'b00};
        target_bad = 1'b0;
`endif
    end

    // Next-state logic; a branch outranks every other event in every state.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        kill_d     = kill_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;

        case (state_q)
            S_IDLE: begin
                if (branch_i) begin
                    pc_d    = target;
                    state_d = target_bad ? S_FAULT : S_REQ;
                end else begin
                    state_d = S_REQ;
                end
            end

            S_REQ: begin
                if (branch_i) begin
                    // A grant in the same cycle fetches the stale address; kill it.
                    pc_d    = target;
                    kill_d  = imem_gnt_i;
                    if (target_bad)
                        state_d = S_FAULT;
                    else if (imem_gnt_i)
                        state_d = S_WAIT;
                    else
                        state_d = S_REQ;
                end else if (imem_gnt_i) begin
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (branch_i) begin
                    pc_d = target;
                    if (imem_rvalid_i) begin
                        kill_d  = 1'b0;
                        state_d = target_bad ? S_FAULT : S_REQ;
                    end else begin
                        kill_d  = 1'b1;
                        state_d = target_bad ? S_FAULT : S_WAIT;
                    end
                end else if (imem_rvalid_i) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        instr_d    = imem_rdata_i;
                        instr_pc_d = pc_q;
                        state_d    = S_HOLD;
                    end
                end
            end

            S_HOLD: begin
                if (branch_i) begin
                    pc_d    = target;
                    state_d = target_bad ? S_FAULT : S_REQ;
                end else if (instr_ready_i) begin
                    pc_d    = pc_q + PC_INC;
                    state_d = S_REQ;
                end
            end

            S_FAULT: begin
                if (branch_i) begin
                    // A still-pending killed response must drain before a new request.
                    pc_d   = target;
                    kill_d = kill_q & ~imem_rvalid_i;
                    if (target_bad)
                        state_d = S_FAULT;
                    else if (kill_q && !imem_rvalid_i)
                        state_d = S_WAIT;
                    else
                        state_d = S_REQ;
                end else if (imem_rvalid_i) begin
                    kill_d = 1'b0;
                end
            end

            default: begin
                state_d = S_IDLE;
                kill_d  = 1'b0;
            end
        endcase
    end

    // State, PC and held-instruction registers; reset aborts any transaction.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            kill_q     <= 1'b0;
            instr_q    <= 32'h0;
            instr_pc_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            kill_q     <= kill_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
        end
    end

    // All outputs decode straight from registers.
    assign imem_req_o    = (state_q == S_REQ);
    assign imem_addr_o   = pc_q;
    assign instr_valid_o = (state_q == S_HOLD);
    assign instr_o       = instr_q;
    assign instr_pc_o    = instr_pc_q;
`ifdef PC_MISALIGN_TRAP_EN
    assign misalign_o    = (state_q == S_FAULT);
`else
    assign misalign_o    = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: directed bench for fetch_pc_unit with hand-computed
// expectations. Inputs change 1 time unit after each rising edge and
// outputs are sampled at that same point.
module tb_fetch_pc_unit;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        branch_i;
    logic [31:0] base_i;
    logic [31:0] offset_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        misalign_o;

    int n_chk  = 0;
    int n_pass = 0;

    fetch_pc_unit dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .branch_i     (branch_i),
        .base_i       (base_i),
        .offset_i     (offset_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_gnt_i   (imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i (imem_rdata_i),
        .instr_valid_o(instr_valid_o),
        .instr_ready_i(instr_ready_i),
        .instr_o      (instr_o),
        .instr_pc_o   (instr_pc_o),
        .misalign_o   (misalign_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clr_in();
        branch_i      = 1'b0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        instr_ready_i = 1'b0;
    endtask

    task automatic do_branch(input logic [31:0] b, input logic [31:0] o);
        branch_i = 1'b1;
        base_i   = b;
        offset_i = o;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n_i = 1'b0;
        base_i = 32'h0; offset_i = 32'h0; imem_rdata_i = 32'h0;
        clr_in();
        step(); step();

        // Reset state
        chk("rst_req",    {31'h0, imem_req_o},    32'h0);
        chk("rst_addr",   imem_addr_o,            32'h0);
        chk("rst_valid",  {31'h0, instr_valid_o}, 32'h0);
        chk("rst_instr",  instr_o,                32'h0);
        chk("rst_ipc",    instr_pc_o,             32'h0);
        chk("rst_mis",    {31'h0, misalign_o},    32'h0);

        // First fetch: IDLE -> REQ -> WAIT -> HOLD
        rst_n_i = 1'b1;
        step();
        chk("f0_req",  {31'h0, imem_req_o}, 32'h1);
        chk("f0_addr", imem_addr_o, 32'h0);
        imem_gnt_i = 1'b1;
        step();
        imem_gnt_i = 1'b0;
        chk("f0_wait_req", {31'h0, imem_req_o}, 32'h0);
        imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0000_0013;
        step();
        imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
        chk("f0_valid", {31'h0, instr_valid_o}, 32'h1);
        chk("f0_instr", instr_o, 32'h0000_0013);
        chk("f0_ipc",   instr_pc_o, 32'h0);

        // Decode stalls for 5 cycles
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_valid", {31'h0, instr_valid_o}, 32'h1);
            chk("stall_instr", instr_o, 32'h0000_0013);
            chk("stall_ipc",   instr_pc_o, 32'h0);
            chk("stall_req",   {31'h0, imem_req_o}, 32'h0);
        end
        instr_ready_i = 1'b1;
        step();
        instr_ready_i = 1'b0;
        chk("seq_valid", {31'h0, instr_valid_o}, 32'h0);
        chk("seq_req",   {31'h0, imem_req_o}, 32'h1);
        chk("seq_addr",  imem_addr_o, 32'h4);

        // Branch while waiting: response is dropped, refetch at 0x140
        imem_gnt_i = 1'b1;
        step();
        imem_gnt_i = 1'b0;
        do_branch(32'h100, 32'h40);
        step();
        branch_i = 1'b0;
        chk("bw_req", {31'h0, imem_req_o}, 32'h0);
        imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF;
        step();
        imem_rvalid_i = 1'b0;
        chk("bw_valid", {31'h0, instr_valid_o}, 32'h0);
        chk("bw_req2",  {31'h0, imem_req_o}, 32'h1);
        chk("bw_addr",  imem_addr_o, 32'h140);

        // Branch in REQ moves the address to 8
        do_branch(32'h0, 32'h8);
        step();
        branch_i = 1'b0;
        chk("br_req_addr", imem_addr_o, 32'h8);
        chk("br_req_req",  {31'h0, imem_req_o}, 32'h1);

        // Branch together with grant at 8: response for 8 discarded
        imem_gnt_i = 1'b1;
        do_branch(32'h0, 32'h20);
        step();
        imem_gnt_i = 1'b0; branch_i = 1'b0;
        chk("bg_req", {31'h0, imem_req_o}, 32'h0);
        imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0BAD_0BAD;
        step();
        imem_rvalid_i = 1'b0;
        chk("bg_valid", {31'h0, instr_valid_o}, 32'h0);
        chk("bg_addr",  imem_addr_o, 32'h20);
        chk("bg_req2",  {31'h0, imem_req_o}, 32'h1);

        // Normal fetch at 0x20
        imem_gnt_i = 1'b1;
        step();
        imem_gnt_i = 1'b0;
        imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0000_1111;
        step();
        imem_rvalid_i = 1'b0;
        chk("f20_instr", instr_o, 32'h0000_1111);
        chk("f20_ipc",   instr_pc_o, 32'h20);

        // Branch and ready together in HOLD; target wraps to 0x10
        do_branch(32'hFFFF_FFF0, 32'h20);
        instr_ready_i = 1'b1;
        step();
        branch_i = 1'b0; instr_ready_i = 1'b0;
        chk("bh_valid", {31'h0, instr_valid_o}, 32'h0);
        chk("bh_addr",  imem_addr_o, 32'h10);

        // Sequential wrap from 0xFFFF_FFFC to 0
        do_branch(32'hFFFF_FFF0, 32'hC);
        step();
        branch_i = 1'b0;
        chk("wr_addr", imem_addr_o, 32'hFFFF_FFFC);
        imem_gnt_i = 1'b1;
        step();
        imem_gnt_i = 1'b0;
        imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0000_2222;
        step();
        imem_rvalid_i = 1'b0;
        chk("wr_ipc", instr_pc_o, 32'hFFFF_FFFC);
        instr_ready_i = 1'b1;
        step();
        instr_ready_i = 1'b0;
        chk("wr_next", imem_addr_o, 32'h0);

        // Misaligned target 0x102
        do_branch(32'h100, 32'h2);
        step();
        branch_i = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
        chk("mis_flag",  {31'h0, misalign_o}, 32'h1);
        chk("mis_valid", {31'h0, instr_valid_o}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            chk("mis_noreq", {31'h0, imem_req_o}, 32'h0);
            step();
        end
        do_branch(32'h200, 32'h0);
        step();
        branch_i = 1'b0;
        chk("mis_clear", {31'h0, misalign_o}, 32'h0);
        chk("mis_req",   {31'h0, imem_req_o}, 32'h1);
        chk("mis_addr",  imem_addr_o, 32'h200);
`else
        chk("mis_flag", {31'h0, misalign_o}, 32'h0);
        chk("mis_req",  {31'h0, imem_req_o}, 32'h1);
        chk("mis_addr", imem_addr_o, 32'h100);
`endif

        // Reset mid-transaction, then a late response must be ignored
        imem_gnt_i = 1'b1;
        step();
        imem_gnt_i = 1'b0;
        rst_n_i = 1'b0;
        #1;
        chk("mr_req",   {31'h0, imem_req_o}, 32'h0);
        chk("mr_addr",  imem_addr_o, 32'h0);
        chk("mr_valid", {31'h0, instr_valid_o}, 32'h0);
        rst_n_i = 1'b1;
        imem_rvalid_i = 1'b1; imem_rdata_i = 32'h5555_5555;
        step();
        chk("mr_req2",   {31'h0, imem_req_o}, 32'h1);
        chk("mr_valid2", {31'h0, instr_valid_o}, 32'h0);
        step();
        imem_rvalid_i = 1'b0;
        chk("mr_valid3", {31'h0, instr_valid_o}, 32'h0);
        chk("mr_instr",  instr_o, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
